// File: rtl/pacman_pkg.sv
// Shared types and default scoring constants for the pellet/score logic.
package pacman_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int PELLET_PTS_DEF = 10;
  localparam int POWER_PTS_DEF  = 50;

  typedef enum logic {RUN, CLEAR} state_t;

endpackage

// File: rtl/bcd_score_adder.sv
// Adds a 2-digit BCD constant into a multi-digit BCD score; saturate flags
// a decimal carry out of the top digit.
module bcd_score_adder
  import pacman_pkg::*;
#(
  parameter int DIGITS = 5
) (
  input  logic [4*DIGITS-1:0] score_in,
  input  logic [7:0]          pts,
  output logic [4*DIGITS-1:0] sum,
  output logic                saturate
);

  always_comb begin
    logic       carry;
    logic [4:0] t;
    bcd_digit_t addend;
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      addend = (i == 0) ? pts[3:0] : (i == 1) ? pts[7:4] : 4'd0;
      t = {1'b0, score_in[4*i +: 4]} + {1'b0, addend} + {4'd0, carry};
      if (t > 5'd9) begin
        t     = t - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum[4*i +: 4] = t[3:0];
    end
    saturate = carry;
  end

endmodule

// File: rtl/pellet_score_tracker.sv
// Turns first rising edges of per-pellet collision flags into one scoring event per clock.
// Optional frightened-mode timer enabled by defining POWER_PELLET_EN.
module pellet_score_tracker
  import pacman_pkg::*;
#(
  parameter int           N_PELLETS    = 64,
  parameter int           SCORE_DIGITS = 5,
  parameter int           PELLET_PTS   = PELLET_PTS_DEF,
  parameter int           POWER_PTS    = POWER_PTS_DEF,
  parameter logic [255:0] POWER_MASK   = 256'h8001,
  parameter int           POWER_FRAMES = 360,
  localparam int CNT_W = $clog2(N_PELLETS + 1),
  localparam int IDX_W = (N_PELLETS > 1) ? $clog2(N_PELLETS) : 1,
  localparam int SW    = 4 * SCORE_DIGITS
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [N_PELLETS-1:0] collided,
  input  logic                 frame_tick,
  output logic [SW-1:0]        score,
  output logic [CNT_W-1:0]     pellets_left,
  output logic                 eat_pulse,
  output logic [IDX_W-1:0]     eat_idx,
  output logic                 level_clear,
  output logic                 power_active
);

  function automatic logic [IDX_W-1:0] lowest_set(input logic [N_PELLETS-1:0] v);
    lowest_set = '0;
    for (int i = N_PELLETS - 1; i >= 0; i--)
      if (v[i]) lowest_set = IDX_W'(i);
  endfunction

  function automatic logic [SW-1:0] sat_score();
    sat_score = '0;
    for (int i = 1; i < SCORE_DIGITS; i++) sat_score[4*i +: 4] = 4'd9;
  endfunction

  function automatic logic [7:0] to_bcd(input int pts);
    to_bcd = {4'(pts / 10), 4'(pts % 10)};
  endfunction

  state_t               state_q, state_d;
  logic [N_PELLETS-1:0] collided_q, pending, eaten;
  logic [N_PELLETS-1:0] edges, award_mask;
  logic                 award;
  logic [IDX_W-1:0]     award_idx;
  logic [7:0]           award_pts;
  logic [SW-1:0]        sum;
  logic                 saturate;
  logic                 is_power;

  always_comb begin
    state_d    = state_q;
    award      = 1'b0;
    award_idx  = lowest_set(pending);
    award_mask = '0;
    edges      = '0;
    is_power   = 1'b0;
    award_pts  = to_bcd(PELLET_PTS);
    if (state_q == RUN) begin
      edges = collided & ~collided_q & ~eaten;
      if (pending != '0) begin
        award                 = 1'b1;
        award_mask[award_idx] = 1'b1;
        if (pellets_left == CNT_W'(1)) state_d = CLEAR;
      end
    end
`ifdef POWER_PELLET_EN
    is_power = award && POWER_MASK[award_idx];
    if (is_power) award_pts = to_bcd(POWER_PTS);
`endif
  end

  bcd_score_adder #(.DIGITS(SCORE_DIGITS)) u_adder (
    .score_in (score),
    .pts      (award_pts),
    .sum      (sum),
    .saturate (saturate)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Stage 1: edge capture into pending; stage 2: award lowest pending index
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      collided_q   <= '0;
      pending      <= '0;
      eaten        <= '0;
      score        <= '0;
      pellets_left <= CNT_W'(N_PELLETS);
      eat_pulse    <= 1'b0;
      eat_idx      <= '0;
    end else begin
      collided_q <= collided;
      pending    <= (pending | edges) & ~award_mask;
      eaten      <= eaten | award_mask;
      eat_pulse  <= award;
      if (award) begin
        eat_idx      <= award_idx;
        score        <= saturate ? sat_score() : sum;
        pellets_left <= pellets_left - CNT_W'(1);
      end
    end
  end

  assign level_clear = (state_q == CLEAR);

`ifdef POWER_PELLET_EN
  localparam int TMR_W = $clog2(POWER_FRAMES + 1);
  logic [TMR_W-1:0] frames_left;

  // A reload from a new power pellet takes priority over a coincident tick
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      frames_left <= '0;
    else if (is_power)
      frames_left <= TMR_W'(POWER_FRAMES);
    else if (frame_tick && frames_left != '0)
      frames_left <= frames_left - TMR_W'(1);
  end

  assign power_active = (frames_left != '0);
`else
  logic unused_cfg;
  assign unused_cfg   = ^{frame_tick, is_power, POWER_MASK, POWER_PTS, POWER_FRAMES};
  assign power_active = 1'b0;
`endif

endmodule

// File: tb/tb_pellet_score_tracker.sv
// Directed bench for pellet_score_tracker (main 64-pellet instance plus two 4-pellet, 2-digit instances).
module tb_pellet_score_tracker;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [63:0] collided;
  logic [3:0]  collided4;
  logic        frame_tick;

  logic [19:0] score;
  logic [6:0]  pellets_left;
  logic        eat_pulse;
  logic [5:0]  eat_idx;
  logic        level_clear, power_active;

  logic [7:0]  s10_score, s50_score;
  logic [2:0]  s10_left, s50_left;
  logic        s10_pulse, s50_pulse, s10_clear, s50_clear, s10_pa, s50_pa;
  logic [1:0]  s10_idx, s50_idx;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  pellet_score_tracker dut (
    .Clk(Clk), .Reset(Reset), .collided(collided), .frame_tick(frame_tick),
    .score(score), .pellets_left(pellets_left), .eat_pulse(eat_pulse),
    .eat_idx(eat_idx), .level_clear(level_clear), .power_active(power_active)
  );

  pellet_score_tracker #(.N_PELLETS(4), .SCORE_DIGITS(2), .PELLET_PTS(10), .POWER_MASK('0)) u_s10 (
    .Clk(Clk), .Reset(Reset), .collided(collided4), .frame_tick(frame_tick),
    .score(s10_score), .pellets_left(s10_left), .eat_pulse(s10_pulse),
    .eat_idx(s10_idx), .level_clear(s10_clear), .power_active(s10_pa)
  );

  pellet_score_tracker #(.N_PELLETS(4), .SCORE_DIGITS(2), .PELLET_PTS(50), .POWER_MASK('0)) u_s50 (
    .Clk(Clk), .Reset(Reset), .collided(collided4), .frame_tick(frame_tick),
    .score(s50_score), .pellets_left(s50_left), .eat_pulse(s50_pulse),
    .eat_idx(s50_idx), .level_clear(s50_clear), .power_active(s50_pa)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; collided = '0; collided4 = '0; frame_tick = 1'b0;
    step(); step();
    vectors++;
    if (score !== 20'h00000 || pellets_left !== 7'd64 || eat_pulse !== 1'b0 ||
        eat_idx !== 6'd0 || level_clear !== 1'b0 || power_active !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_main: score=%h left=%0d pulse=%b idx=%0d clr=%b pa=%b, want 00000 64 0 0 0 0",
               score, pellets_left, eat_pulse, eat_idx, level_clear, power_active);
    end
    vectors++;
    if (s10_score !== 8'h00 || s10_left !== 3'd4 || s10_clear !== 1'b0 || s10_pa !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_small: score=%h left=%0d clr=%b pa=%b, want 00 4 0 0", s10_score, s10_left, s10_clear, s10_pa);
    end
    Reset = 1'b0;
  endtask

  task automatic test_single();
    collided[3] = 1'b1;
    step();
    vectors++;
    if (eat_pulse !== 1'b0) begin
      miscompares++; $display("FAIL single_early: eat_pulse=%b at t+1, want 0", eat_pulse);
    end
    step();
    vectors++;
    if (eat_pulse !== 1'b1 || eat_idx !== 6'd3 || score !== 20'h00010 || pellets_left !== 7'd63) begin
      miscompares++;
      $display("FAIL single_award: pulse=%b idx=%0d score=%h left=%0d, want 1 3 00010 63",
               eat_pulse, eat_idx, score, pellets_left);
    end
    step();
    vectors++;
    if (eat_pulse !== 1'b0 || score !== 20'h00010) begin
      miscompares++; $display("FAIL single_after: pulse=%b score=%h, want 0 00010", eat_pulse, score);
    end
  endtask

  task automatic test_simultaneous();
    int exp_idx [3] = '{2, 5, 9};
    collided[9] = 1'b1; collided[5] = 1'b1; collided[2] = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (eat_pulse !== 1'b1 || eat_idx !== 6'(exp_idx[i])) begin
        miscompares++;
        $display("FAIL simul_order%0d: pulse=%b idx=%0d, want 1 %0d", i, eat_pulse, eat_idx, exp_idx[i]);
      end
    end
    step();
    vectors++;
    if (eat_pulse !== 1'b0 || score !== 20'h00040 || pellets_left !== 7'd60) begin
      miscompares++;
      $display("FAIL simul_total: pulse=%b score=%h left=%0d, want 0 00040 60", eat_pulse, score, pellets_left);
    end
  endtask

  task automatic test_refire();
    int pulses = 0;
    collided[3] = 1'b0;
    step(); step();
    collided[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (eat_pulse === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 0 || score !== 20'h00040 || pellets_left !== 7'd60) begin
      miscompares++;
      $display("FAIL refire: pulses=%0d score=%h left=%0d, want 0 00040 60", pulses, score, pellets_left);
    end
  endtask

  task automatic frame_pulse();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

`ifdef POWER_PELLET_EN
  task automatic test_power();
    int n = 0;
    collided[0] = 1'b1;
    step(); step();
    vectors++;
    if (eat_idx !== 6'd0 || score !== 20'h00090 || power_active !== 1'b1) begin
      miscompares++;
      $display("FAIL power_award: idx=%0d score=%h pa=%b, want 0 00090 1", eat_idx, score, power_active);
    end
    for (int i = 0; i < 100; i++) frame_pulse();
    vectors++;
    if (power_active !== 1'b1) begin
      miscompares++; $display("FAIL power_mid: power_active=%b after 100 ticks, want 1", power_active);
    end
    collided[15] = 1'b1;
    step(); step();
    vectors++;
    if (score !== 20'h00140 || pellets_left !== 7'd58 || power_active !== 1'b1) begin
      miscompares++;
      $display("FAIL power_reload: score=%h left=%0d pa=%b, want 00140 58 1", score, pellets_left, power_active);
    end
    while (power_active === 1'b1 && n < 1000) begin
      frame_pulse();
      n++;
    end
    vectors++;
    if (n != 360) begin
      miscompares++; $display("FAIL power_duration: ticks=%0d, want 360", n);
    end
  endtask
`else
  task automatic test_power();
    collided[0] = 1'b1;
    step(); step();
    vectors++;
    if (eat_pulse !== 1'b1 || eat_idx !== 6'd0 || score !== 20'h00050 || pellets_left !== 7'd59) begin
      miscompares++;
      $display("FAIL plain_idx0: pulse=%b idx=%0d score=%h left=%0d, want 1 0 00050 59",
               eat_pulse, eat_idx, score, pellets_left);
    end
    for (int i = 0; i < 3; i++) frame_pulse();
    vectors++;
    if (power_active !== 1'b0) begin
      miscompares++; $display("FAIL plain_power_active: %b, want 0", power_active);
    end
  endtask
`endif

  task automatic test_level_clear();
    logic [7:0] exp10 [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
    logic [7:0] exp50 [4] = '{8'h50, 8'h90, 8'h90, 8'h90};
    int pulses = 0;
    collided4 = 4'hF;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (s10_pulse !== 1'b1 || s10_idx !== 2'(i) || s10_score !== exp10[i] ||
          s50_score !== exp50[i] || s10_clear !== (i == 3)) begin
        miscompares++;
        $display("FAIL clear_seq%0d: pulse=%b idx=%0d s10=%h s50=%h clr=%b, want 1 %0d %h %h %b",
                 i, s10_pulse, s10_idx, s10_score, s50_score, s10_clear, i, exp10[i], exp50[i], (i == 3));
      end
    end
    collided4 = 4'h0;
    step();
    collided4 = 4'h5;
    for (int i = 0; i < 4; i++) begin
      step();
      if (s10_pulse === 1'b1 || s50_pulse === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 0 || s10_score !== 8'h40 || s50_score !== 8'h90 || s10_left !== 3'd0 ||
        s10_clear !== 1'b1 || s50_clear !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_hold: pulses=%0d s10=%h s50=%h left=%0d clr=%b/%b, want 0 40 90 0 1/1",
               pulses, s10_score, s50_score, s10_left, s10_clear, s50_clear);
    end
  endtask

  task automatic test_reset_midrun();
    collided[20] = 1'b1; collided[21] = 1'b1; collided[22] = 1'b1;
    step(); step();
    #2 Reset = 1'b1;
    #1;
    vectors++;
    if (score !== 20'h00000 || pellets_left !== 7'd64 || eat_pulse !== 1'b0 || eat_idx !== 6'd0 ||
        level_clear !== 1'b0 || power_active !== 1'b0 || s10_clear !== 1'b0 || s50_score !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_async: score=%h left=%0d pulse=%b idx=%0d clr=%b pa=%b sclr=%b s50=%h",
               score, pellets_left, eat_pulse, eat_idx, level_clear, power_active, s10_clear, s50_score);
    end
    collided = '0; collided4 = '0;
    step();
    Reset = 1'b0;
    step(); step();
    vectors++;
    if (eat_pulse !== 1'b0 || score !== 20'h00000) begin
      miscompares++; $display("FAIL reset_pending_cleared: pulse=%b score=%h, want 0 00000", eat_pulse, score);
    end
    collided[3] = 1'b1;
    step(); step();
    vectors++;
    if (eat_pulse !== 1'b1 || eat_idx !== 6'd3 || score !== 20'h00010 || pellets_left !== 7'd63) begin
      miscompares++;
      $display("FAIL reset_eaten_cleared: pulse=%b idx=%0d score=%h left=%0d, want 1 3 00010 63",
               eat_pulse, eat_idx, score, pellets_left);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_refire();
    test_power();
    test_level_clear();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
